seq_detector: RTL and testbench

Parametrised serial pattern detector with a registered Mealy-style output. It samples a one-bit qualified input stream, compares the last `PAT_LEN` valid bits against a compile-time `PATTERN`, and pulses `yout` for one cycle on each match. Overlapping and non-overlapping detection are selectable at run time, and an optional saturating match counter can be compiled in. It generalises the team's fixed two-state FSM blocks and sits between a serial front end and the control logic that consumes match events.

---
 rtl/seq_detector.sv | 99 +++++++++
 tb/tb_seq_detector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detector : serial pattern detector with a registered match pulse.
//   Optional saturating match counter is built when SEQ_DETECTOR_COUNT_EN is defined.
//   Rev 1.0
// ---------------------------------------------------------------------------
module seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         xin_valid,
  input  logic                         xin,
  input  logic                         overlap,
  output logic                         yout,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] window_q, window_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               yout_q, yout_d;
  logic [PAT_LEN-1:0] w_n;
  logic [FW-1:0]      f_n;
  logic               hit;

  // Fill qualifies the compare so an all-zero pattern cannot match a cleared window.
  always_comb begin
    w_n = {window_q[PAT_LEN-2:0], xin};
    f_n = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    hit = xin_valid && (f_n == FULL) && (w_n == PATTERN);
  end

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    yout_d   = 1'b0;
    if (xin_valid) begin
      yout_d = hit;
      if (hit && !overlap) begin
        window_d = '0;
        fill_d   = '0;
      end else begin
        window_d = w_n;
        fill_d   = f_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      window_q <= '0;
      fill_q   <= '0;
      yout_q   <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      yout_q   <= yout_d;
    end
  end

  assign yout = yout_q;
  assign fill = fill_q;

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hit && !sat_q) cnt_d = cnt_q + 1'b1;
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// Directed scoreboard bench for seq_detector: three instances cover the
// default pattern, an all-zero pattern and a 2-bit pattern with a 2-bit counter.
module tb_seq_detector;

`ifdef SEQ_DETECTOR_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic v0, x0, o0, v1, x1, o1, v2, x2, o2;
  logic       y0, y1, y2, s0, s1, s2;
  logic [2:0] f0, f1;
  logic [1:0] f2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  seq_detector u0 (.clk(clk), .rst(rst), .xin_valid(v0), .xin(x0), .overlap(o0),
                   .yout(y0), .fill(f0), .match_cnt(c0), .cnt_sat(s0));
  seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u1 (
                   .clk(clk), .rst(rst), .xin_valid(v1), .xin(x1), .overlap(o1),
                   .yout(y1), .fill(f1), .match_cnt(c1), .cnt_sat(s1));
  seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) u2 (
                   .clk(clk), .rst(rst), .xin_valid(v2), .xin(x2), .overlap(o2),
                   .yout(y2), .fill(f2), .match_cnt(c2), .cnt_sat(s2));

  typedef struct {
    int    dut;
    string tag;
    int    y;
    int    f;
    int    c;
    int    s;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int ce(input int n);
    return CEN ? n : 0;
  endfunction

  task automatic cmp(input string tag, input string fld, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic check_one();
    exp_t e;
    int oy, of, oc, os;
    e = sb.pop_front();
    case (e.dut)
      0:       begin oy = int'(y0); of = int'(f0); oc = int'(c0); os = int'(s0); end
      1:       begin oy = int'(y1); of = int'(f1); oc = int'(c1); os = int'(s1); end
      default: begin oy = int'(y2); of = int'(f2); oc = int'(c2); os = int'(s2); end
    endcase
    cmp(e.tag, "yout", oy, e.y);
    cmp(e.tag, "fill", of, e.f);
    cmp(e.tag, "cnt",  oc, e.c);
    cmp(e.tag, "sat",  os, e.s);
  endtask

  task automatic push(input int d, input string tag, input int ey, input int ef,
                      input int ec, input int es);
    exp_t e;
    e.dut = d; e.tag = tag; e.y = ey; e.f = ef; e.c = ec; e.s = es;
    sb.push_back(e);
  endtask

  // One clock on DUT d; inputs set #1 after the previous edge, outputs checked #1 after this one.
  task automatic step(input int d, input bit v, input bit x, input bit ov, input string tag,
                      input int ey, input int ef, input int ec, input int es);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    case (d)
      0:       begin v0 = v; x0 = x; o0 = ov; end
      1:       begin v1 = v; x1 = x; o1 = ov; end
      default: begin v2 = v; x2 = x; o2 = ov; end
    endcase
    push(d, tag, ey, ef, ec, es);
    @(posedge clk); #1;
    check_one();
  endtask

  task automatic do_reset(input string tag, input bit v, input bit x);
    rst = 1'b0;
    v0 = v; x0 = x; v1 = v; x1 = x; v2 = v; x2 = x;
    for (int d = 0; d < 3; d++) push(d, tag, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) check_one();
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    {v0, x0, o0, v1, x1, o1, v2, x2, o2} = '0;
    @(posedge clk); #1;
    do_reset("reset", 1'b0, 1'b0);

    // Overlapping: 1,0,1,1,0,1,1 matches after bits 4 and 7
    step(0, 1, 1, 1, "ov_b1", 0, 1, ce(0), 0);
    step(0, 1, 0, 1, "ov_b2", 0, 2, ce(0), 0);
    step(0, 1, 1, 1, "ov_b3", 0, 3, ce(0), 0);
    step(0, 1, 1, 1, "ov_b4", 1, 4, ce(1), 0);
    step(0, 1, 0, 1, "ov_b5", 0, 4, ce(1), 0);
    step(0, 1, 1, 1, "ov_b6", 0, 4, ce(1), 0);
    step(0, 1, 1, 1, "ov_b7", 1, 4, ce(2), 0);
    step(0, 0, 0, 1, "ov_idle", 0, 4, ce(2), 0);

    // Non-overlapping: same stream, only the first match
    do_reset("rst_nov", 1'b1, 1'b1);
    step(0, 1, 1, 0, "nov_b1", 0, 1, ce(0), 0);
    step(0, 1, 0, 0, "nov_b2", 0, 2, ce(0), 0);
    step(0, 1, 1, 0, "nov_b3", 0, 3, ce(0), 0);
    step(0, 1, 1, 0, "nov_b4", 1, 0, ce(1), 0);
    step(0, 1, 0, 0, "nov_b5", 0, 1, ce(1), 0);
    step(0, 1, 1, 0, "nov_b6", 0, 2, ce(1), 0);
    step(0, 1, 1, 0, "nov_b7", 0, 3, ce(1), 0);

    // Gaps of 0, 2 and 3 idle cycles do not break a partial match
    do_reset("rst_gap", 1'b0, 1'b0);
    step(0, 1, 1, 1, "gap_b1", 0, 1, ce(0), 0);
    step(0, 1, 0, 1, "gap_b2", 0, 2, ce(0), 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, "gap_i2", 0, 2, ce(0), 0);
    step(0, 1, 1, 1, "gap_b3", 0, 3, ce(0), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "gap_i3", 0, 3, ce(0), 0);
    step(0, 1, 1, 1, "gap_b4", 1, 4, ce(1), 0);
    step(0, 0, 1, 1, "gap_end", 0, 4, ce(1), 0);

    // Reset mid-pattern discards partial window
    do_reset("rst_mid0", 1'b0, 1'b0);
    step(0, 1, 1, 1, "mid_b1", 0, 1, ce(0), 0);
    step(0, 1, 0, 1, "mid_b2", 0, 2, ce(0), 0);
    step(0, 1, 1, 1, "mid_b3", 0, 3, ce(0), 0);
    do_reset("rst_mid", 1'b1, 1'b1);
    step(0, 1, 1, 1, "mid_b4", 0, 1, ce(0), 0);

    // All-zero pattern needs four real bits
    do_reset("rst_zero", 1'b0, 1'b0);
    step(1, 1, 0, 1, "z_b1", 0, 1, ce(0), 0);
    step(1, 1, 0, 1, "z_b2", 0, 2, ce(0), 0);
    step(1, 1, 0, 1, "z_b3", 0, 3, ce(0), 0);
    step(1, 1, 0, 1, "z_b4", 1, 4, ce(1), 0);

    // 2-bit pattern 11, 2-bit counter saturates at 3
    step(2, 1, 1, 1, "sat_b1", 0, 1, ce(0), 0);
    step(2, 1, 1, 1, "sat_b2", 1, 2, ce(1), 0);
    step(2, 1, 1, 1, "sat_b3", 1, 2, ce(2), 0);
    step(2, 1, 1, 1, "sat_b4", 1, 2, ce(3), ce(1));
    step(2, 1, 1, 1, "sat_b5", 1, 2, ce(3), ce(1));
    step(2, 1, 1, 1, "sat_b6", 1, 2, ce(3), ce(1));
    step(2, 0, 1, 1, "sat_idle", 0, 2, ce(3), ce(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
